// File: rtl/matrix_mult_seq_pkg.sv
// Shared types and helpers for the sequential NxN matrix multiplier.
// Build option MATMUL_SAT_EN (see matrix_mult_seq_mac) selects saturating result formatting.
package matrix_mult_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Accumulator width that can hold a full N-term dot product without overflow.
  function automatic int unsigned acc_w(int unsigned n, int unsigned dw);
    return 2 * dw + $clog2(n);
  endfunction

  // Row-major element index inside a flattened NxN matrix.
  function automatic int unsigned elem_idx(int unsigned r, int unsigned c, int unsigned n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matrix_mult_seq_if.sv
// Operand/result handshake bundle for matrix_mult_seq.
// The master side supplies operands and consumes results.
interface matrix_mult_seq_if #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [N*N*DW-1:0]   a_flat;
  logic [N*N*DW-1:0]   b_flat;
  logic                out_valid;
  logic                out_ready;
  logic [N*N*DW-1:0]   c_flat;
  logic                busy;

  modport master (
    output in_valid, a_flat, b_flat, out_ready,
    input  in_ready, out_valid, c_flat, busy
  );

  modport slave (
    input  in_valid, a_flat, b_flat, out_ready,
    output in_ready, out_valid, c_flat, busy
  );
endinterface

// File: rtl/matrix_mult_seq_mac.sv
// Combinational multiply-accumulate step with result formatting.
// MATMUL_SAT_EN defined: results saturate to 2^DW-1; otherwise they wrap modulo 2^DW.
module matrix_mult_seq_mac #(
  parameter int unsigned DW    = 16,
  parameter int unsigned ACC_W = 34
) (
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [ACC_W-1:0] acc,
  input  logic             last,
  output logic [ACC_W-1:0] next_acc,
  output logic [DW-1:0]    elem
);
  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] sum;

  assign prod = a * b;
  assign sum  = acc + ACC_W'(prod);

  // Clear the accumulator once the dot product for this element completes.
  assign next_acc = last ? '0 : sum;

`ifdef MATMUL_SAT_EN
  assign elem = (sum > ACC_W'({DW{1'b1}})) ? {DW{1'b1}} : sum[DW-1:0];
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[ACC_W-1:DW];
  assign elem = sum[DW-1:0];
`endif

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential NxN unsigned matrix multiplier C = A x B using a single shared MAC.
// One MAC per cycle over (i, j, k); result valid N^3 edges after operand accept.
// Build option MATMUL_SAT_EN selects saturating element formatting in the MAC.
module matrix_mult_seq
  import matrix_mult_seq_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned DW    = 16,
  parameter int unsigned ACC_W = acc_w(N, DW)
) (
  input logic              clk,
  input logic              rst,
  matrix_mult_seq_if.slave bus
);
  localparam int unsigned TW = N * N * DW;
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] CntLast = CW'(N - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;

  logic              k_last;
  logic [DW-1:0]     mac_a, mac_b, mac_elem;
  logic [ACC_W-1:0]  mac_next_acc;

  assign k_last = (k_q == CntLast);
  assign mac_a  = a_q[elem_idx(32'(i_q), 32'(k_q), N) * DW +: DW];
  assign mac_b  = b_q[elem_idx(32'(k_q), 32'(j_q), N) * DW +: DW];

  matrix_mult_seq_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .a        (mac_a),
    .b        (mac_b),
    .acc      (acc_q),
    .last     (k_last),
    .next_acc (mac_next_acc),
    .elem     (mac_elem)
  );

  // State, operand, result and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Next-state: capture on accept, step k then j then i during RUN, hold result in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a_flat;
          b_d     = bus.b_flat;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = mac_next_acc;
        if (k_last) begin
          c_d[elem_idx(32'(i_q), 32'(j_q), N) * DW +: DW] = mac_elem;
          k_d = '0;
          if (j_q == CntLast) begin
            j_d = '0;
            if (i_q == CntLast) begin
              i_d     = '0;
              state_d = StDone;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StRun);
  assign bus.out_valid = (state_q == StDone);
  assign bus.c_flat    = c_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq against a plain-arithmetic matrix product model.
// Build option MATMUL_SAT_EN switches the model to saturating element formatting.
module tb_matrix_mult_seq;
  localparam int unsigned N  = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = N * N * DW;
  localparam int LAT = N * N * N;

  typedef logic [TW-1:0] flat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_mis = 0;

  matrix_mult_seq_if #(.N(N), .DW(DW)) bus ();

  matrix_mult_seq #(
    .N  (N),
    .DW (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Textbook product: each C element is a full-precision dot product, then formatted.
  function automatic flat_t ref_mul(input flat_t a, input flat_t b);
    flat_t c = '0;
    for (int r = 0; r < N; r++) begin
      for (int col = 0; col < N; col++) begin
        longint unsigned s = 0;
        longint unsigned lim = (64'd1 << DW) - 1;
        for (int t = 0; t < N; t++)
          s += longint'(a[(r*N+t)*DW +: DW]) * longint'(b[(t*N+col)*DW +: DW]);
`ifdef MATMUL_SAT_EN
        if (s > lim) s = lim;
`endif
        c[(r*N+col)*DW +: DW] = DW'(s & lim);
      end
    end
    return c;
  endfunction

  function automatic flat_t rand_flat();
    flat_t f;
    for (int e = 0; e < N*N; e++) f[e*DW +: DW] = DW'($urandom);
    return f;
  endfunction

  function automatic flat_t ident_flat();
    flat_t f = '0;
    for (int e = 0; e < N; e++) f[(e*N+e)*DW +: DW] = DW'(1);
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_c(input string tag, input flat_t exp);
    for (int e = 0; e < N*N; e++)
      check($sformatf("%s c[%0d]", tag, e), 64'(bus.c_flat[e*DW +: DW]), 64'(exp[e*DW +: DW]));
  endtask

  // Present operands, wait for acceptance, then scramble the inputs to prove capture.
  task automatic start_op(input string tag, input flat_t a, input flat_t b);
    bus.a_flat   = a;
    bus.b_flat   = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200 && !bus.in_ready; t++) tick();
    check({tag, " ready"}, 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a_flat   = rand_flat();
    bus.b_flat   = rand_flat();
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!bus.out_valid && edges < LAT + 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic full_op(input string tag, input flat_t a, input flat_t b);
    int e;
    start_op(tag, a, b);
    wait_done(e);
    check({tag, " latency"}, 64'(e), 64'(LAT));
    check({tag, " in_ready in done"}, 64'(bus.in_ready), 64'd0);
    check({tag, " busy in done"}, 64'(bus.busy), 64'd0);
    check_c(tag, ref_mul(a, b));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    flat_t a, b, a2, b2, fa, fb;
    flat_t exp_q[$];
    int e, got, sent, last_t;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_flat    = '0;
    bus.b_flat    = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check_c("reset", '0);

    // Counting matrices (the 1..9 by 9..1 example when N=3).
    for (int r = 0; r < N; r++)
      for (int col = 0; col < N; col++) begin
        fa[(r*N+col)*DW +: DW] = DW'(r*N + col + 1);
        fb[(r*N+col)*DW +: DW] = DW'(N*N - (r*N + col));
      end
    full_op("count", fa, fb);

    // All-ones operands exercise wrap / saturation of large dot products.
    full_op("allones", '1, '1);

    b = rand_flat();
    full_op("ident_a", ident_flat(), b);
    a = rand_flat();
    full_op("ident_b", a, ident_flat());
    full_op("random", rand_flat(), rand_flat());

    // Result held while the consumer stalls; new operands ignored until back in IDLE.
    a  = rand_flat();
    b  = rand_flat();
    a2 = rand_flat();
    b2 = rand_flat();
    start_op("stall", a, b);
    wait_done(e);
    check("stall latency", 64'(e), 64'(LAT));
    bus.a_flat   = a2;
    bus.b_flat   = b2;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      check("stall out_valid", 64'(bus.out_valid), 64'd1);
      check("stall in_ready", 64'(bus.in_ready), 64'd0);
      check_c("stall", ref_mul(a, b));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("stall release", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("stall next busy", 64'(bus.busy), 64'd1);
    wait_done(e);
    check("stall next latency", 64'(e), 64'(LAT));
    check_c("stall next", ref_mul(a2, b2));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset during RUN cycle 12 aborts the operation.
    start_op("abort", rand_flat(), rand_flat());
    for (int t = 1; t < 12; t++) tick();
    check("abort busy before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort in_ready", 64'(bus.in_ready), 64'd1);
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    check("abort busy", 64'(bus.busy), 64'd0);
    check_c("abort", '0);
    full_op("after abort", rand_flat(), rand_flat());

    // Back-to-back stream with both handshakes held high.
    for (int q = 0; q < 3; q++) exp_q.push_back('0);
    a = rand_flat();
    b = rand_flat();
    exp_q[0] = ref_mul(a, b);
    bus.a_flat    = a;
    bus.b_flat    = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    got = 0;
    sent = 0;
    last_t = 0;
    for (int t = 0; t < 4 * (LAT + 2) + 20 && got < 3; t++) begin
      logic acc_now;
      if (bus.out_valid) begin
        check_c($sformatf("stream %0d", got), exp_q[got]);
        if (got > 0) check("stream interval", 64'(t - last_t), 64'(LAT + 2));
        last_t = t;
        got++;
      end
      acc_now = bus.in_ready && bus.in_valid;
      tick();
      if (acc_now) begin
        sent++;
        if (sent < 3) begin
          a = rand_flat();
          b = rand_flat();
          exp_q[sent] = ref_mul(a, b);
          bus.a_flat = a;
          bus.b_flat = b;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check("stream count", 64'(got), 64'd3);
    bus.out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
